// File: rtl/shift_chain_595_ctrl.sv
// Serial driver for a daisy chain of 74HC595s: captures a frame on start, shifts it out
// at a programmable SCLK rate and pulses STCP. Define SHIFT595_PWM_EN for PWM brightness on OE.
module shift_chain_595_ctrl #(
  parameter int NUM_ICS = 2,
  parameter int CLK_DIV = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [NUM_ICS*8-1:0]   data_i,
  input  logic                   lsb_first_i,
`ifdef SHIFT595_PWM_EN
  input  logic [7:0]             brightness_i,
`endif
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   sclk_o,
  output logic                   data_o,
  output logic                   latch_o,
  output logic                   oe_n_o
);

  localparam int W     = NUM_ICS * 8;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    CLKHI,
    LATCH
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     shadow_q, shadow_d;
  logic             lsb_q, lsb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             data_q, data_d;
  logic             latch_q, latch_d;
  logic             oe_n_q, oe_n_d;
`ifdef SHIFT595_PWM_EN
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
`endif

  // Bit idx of the frame in shift order: idx 0 is the first bit on DS.
  function automatic logic pick_bit(input logic [W-1:0]     word,
                                    input logic             lsb_first,
                                    input logic [IDX_W-1:0] idx);
    if (lsb_first) begin
      return word[idx];
    end
    return word[IDX_LAST - idx];
  endfunction

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    lsb_d    = lsb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sclk_d   = sclk_q;
    data_d   = data_q;
    latch_d  = latch_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SETUP;
          div_d    = '0;
          idx_d    = '0;
          shadow_d = data_i;
          lsb_d    = lsb_first_i;
          data_d   = pick_bit(data_i, lsb_first_i, '0);
          busy_d   = 1'b1;
          sclk_d   = 1'b0;
          latch_d  = 1'b0;
        end
      end

      SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = CLKHI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      CLKHI: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            latch_d = 1'b1;
            state_d = LATCH;
          end else begin
            // Next bit goes onto DS together with the falling SCLK edge.
            idx_d   = idx_q + IDX_W'(1);
            data_d  = pick_bit(shadow_q, lsb_q, idx_q + IDX_W'(1));
            state_d = SETUP;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef SHIFT595_PWM_EN
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    oe_n_d    = !(pwm_cnt_q < brightness_i);
  end
`else
  always_comb begin
    oe_n_d = 1'b0;
  end
`endif

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      data_q  <= 1'b0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      latch_q <= latch_d;
      oe_n_q  <= oe_n_d;
    end
  end

  // NOTE: frame shadow and order flag have no reset; they are always rewritten on accept.
  always_ff @(posedge clk_i) begin
    shadow_q <= shadow_d;
    lsb_q    <= lsb_d;
  end

`ifdef SHIFT595_PWM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`endif

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sclk_o  = sclk_q;
  assign data_o  = data_q;
  assign latch_o = latch_q;
  assign oe_n_o  = oe_n_q;

endmodule

// File: tb/tb_shift_chain_595_ctrl.sv
// Bench for shift_chain_595_ctrl: two instances (1 IC / div 2, 2 ICs / div 1) checked every
// cycle against a frame-timing model, plus table vectors and directed corner sequences.
module tb_shift_chain_595_ctrl;

  localparam int W_A = 8;
  localparam int D_A = 2;
  localparam int FEND_A = 2 * W_A * D_A + D_A + 1;
  localparam int W_B = 16;
  localparam int D_B = 1;
  localparam int FEND_B = 2 * W_B * D_B + D_B + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_start, a_lsb;
  logic [7:0]    a_din;
  logic          a_busy, a_done, a_sclk, a_dout, a_latch, a_oe_n;
  logic          b_rst, b_start, b_lsb;
  logic [15:0]   b_din;
  logic          b_busy, b_done, b_sclk, b_dout, b_latch, b_oe_n;
`ifdef SHIFT595_PWM_EN
  logic [7:0]    a_bright, b_bright;
`endif

  shift_chain_595_ctrl #(.NUM_ICS(1), .CLK_DIV(D_A)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .start_i(a_start), .data_i(a_din), .lsb_first_i(a_lsb),
`ifdef SHIFT595_PWM_EN
    .brightness_i(a_bright),
`endif
    .busy_o(a_busy), .done_o(a_done), .sclk_o(a_sclk), .data_o(a_dout),
    .latch_o(a_latch), .oe_n_o(a_oe_n)
  );

  shift_chain_595_ctrl #(.NUM_ICS(2), .CLK_DIV(D_B)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .data_i(b_din), .lsb_first_i(b_lsb),
`ifdef SHIFT595_PWM_EN
    .brightness_i(b_bright),
`endif
    .busy_o(b_busy), .done_o(b_done), .sclk_o(b_sclk), .data_o(b_dout),
    .latch_o(b_latch), .oe_n_o(b_oe_n)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame bits in the order they appear on DS.
  function automatic logic [31:0] order_bits(input logic [31:0] d, input logic lsb, input int w);
    logic [31:0] o = '0;
    for (int k = 0; k < w; k++) o[k] = lsb ? d[k] : d[w-1-k];
    return o;
  endfunction

  // Expected {busy, done, sclk, data, latch} at cycle t after accept (t = 0: no frame).
  function automatic logic [4:0] model_out(input int t, input int w, input int d,
                                           input logic [31:0] ord, input logic last);
    int k, ph;
    if (t >= 1 && t <= 2*w*d) begin
      k  = (t - 1) / (2*d);
      ph = (t - 1) % (2*d);
      return {1'b1, 1'b0, (ph >= d), ord[k], 1'b0};
    end
    if (t > 2*w*d && t <= 2*w*d + d) return {1'b1, 1'b0, 1'b0, ord[w-1], 1'b1};
    if (t == 2*w*d + d + 1)          return {1'b0, 1'b1, 1'b0, last, 1'b0};
    return {1'b0, 1'b0, 1'b0, last, 1'b0};
  endfunction

  int          tn_a = 0, tn_b = 0;
  logic [31:0] ord_a = '0, ord_b = '0;
  logic        last_a = 1'b0, last_b = 1'b0;
  logic        oe_exp_a = 1'b1, oe_exp_b = 1'b1;
  logic [7:0]  pwm_a = '0, pwm_b = '0;

  always @(posedge clk) begin : model_a
    logic [4:0] e;
    if (a_rst) begin
      tn_a = 0; last_a = 1'b0; oe_exp_a = 1'b1; pwm_a = '0;
    end else begin
`ifdef SHIFT595_PWM_EN
      oe_exp_a = !(pwm_a < a_bright);
      pwm_a    = pwm_a + 8'd1;
`else
      oe_exp_a = 1'b0;
`endif
      if (a_start && (tn_a == 0 || tn_a == FEND_A)) begin
        tn_a  = 1;
        ord_a = order_bits(32'(a_din), a_lsb, W_A);
      end else if (tn_a == FEND_A) tn_a = 0;
      else if (tn_a != 0) tn_a++;
      e = model_out(tn_a, W_A, D_A, ord_a, last_a);
      last_a = e[1];
    end
  end

  always @(posedge clk) begin : model_b
    logic [4:0] e;
    if (b_rst) begin
      tn_b = 0; last_b = 1'b0; oe_exp_b = 1'b1; pwm_b = '0;
    end else begin
`ifdef SHIFT595_PWM_EN
      oe_exp_b = !(pwm_b < b_bright);
      pwm_b    = pwm_b + 8'd1;
`else
      oe_exp_b = 1'b0;
`endif
      if (b_start && (tn_b == 0 || tn_b == FEND_B)) begin
        tn_b  = 1;
        ord_b = order_bits(32'(b_din), b_lsb, W_B);
      end else if (tn_b == FEND_B) tn_b = 0;
      else if (tn_b != 0) tn_b++;
      e = model_out(tn_b, W_B, D_B, ord_b, last_b);
      last_b = e[1];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_cycle", {a_busy, a_done, a_sclk, a_dout, a_latch, a_oe_n},
            {model_out(tn_a, W_A, D_A, ord_a, last_a), oe_exp_a});
      check("b_cycle", {b_busy, b_done, b_sclk, b_dout, b_latch, b_oe_n},
            {model_out(tn_b, W_B, D_B, ord_b, last_b), oe_exp_b});
    end
  end

  typedef struct {
    logic [7:0] din;
    logic       lsb;
    bit         corrupt;
    logic [7:0] exp_seq;
    int         exp_lf;
    int         exp_ll;
    int         exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_idle_a();
    int n = 0;
    while (a_busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("a_idle_timeout", 32'(a_busy), 0);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (b_busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("b_idle_timeout", 32'(b_busy), 0);
  endtask

  task automatic run_vec_a(input vec_t v);
    logic [7:0] seq = '0;
    logic       prev = 1'b0;
    int         lf = 0, ll = 0, dc = 0;
    wait_idle_a();
    @(negedge clk);
    a_din = v.din; a_lsb = v.lsb; a_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) a_start = 1'b0;
      if (v.corrupt && cyc == 3) begin
        a_din = 8'h00;
        a_lsb = ~a_lsb;
      end
      if (a_sclk && !prev) seq = {seq[6:0], a_dout};
      prev = a_sclk;
      if (a_latch) begin
        if (lf == 0) lf = cyc;
        ll = cyc;
      end
      if (a_done) dc = cyc;
    end
    check("a_seq", 32'(seq), 32'(v.exp_seq));
    check("a_latch_window", {lf[15:0], ll[15:0]}, {v.exp_lf[15:0], v.exp_ll[15:0]});
    check("a_done_cycle", dc, v.exp_done);
  endtask

  initial begin
    int cnt;
    logic [15:0] bseq;
    logic bprev;
    int rises;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 33, 34, 35};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 33, 34, 35};
    vecs[2] = '{8'h01, 1'b0, 1'b0, 8'h01, 33, 34, 35};
    vecs[3] = '{8'h01, 1'b1, 1'b0, 8'h80, 33, 34, 35};
    vecs[4] = '{8'hC8, 1'b1, 1'b1, 8'h13, 33, 34, 35};
    vecs[5] = '{8'hC8, 1'b0, 1'b0, 8'hC8, 33, 34, 35};

    a_rst = 1'b1; a_start = 1'b0; a_din = '0; a_lsb = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_din = '0; b_lsb = 1'b0;
`ifdef SHIFT595_PWM_EN
    a_bright = 8'd128; b_bright = 8'd200;
`endif
    repeat (3) @(negedge clk);
    check("a_reset", {a_busy, a_done, a_sclk, a_dout, a_latch, a_oe_n}, 6'b000001);
    check("b_reset", {b_busy, b_done, b_sclk, b_dout, b_latch, b_oe_n}, 6'b000001);
    chk_en = 1'b1;
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (2) @(negedge clk);
`ifndef SHIFT595_PWM_EN
    check("a_oe_after_reset", 32'(a_oe_n), 0);
`endif

    foreach (vecs[i]) run_vec_a(vecs[i]);

    // Two-IC chain, div 1: start mid-frame ignored, start in done cycle accepted.
    wait_idle_b();
    @(negedge clk);
    b_din = 16'h8001; b_lsb = 1'b0; b_start = 1'b1;
    @(posedge clk);
    cnt = 0; bseq = '0; bprev = 1'b0; rises = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      b_start = (cyc == 10) || (cyc == 34);
      if (cyc <= 33 && b_busy) cnt++;
      if (cyc <= 33 && b_sclk && !bprev) begin
        bseq = {bseq[14:0], b_dout};
        rises++;
      end
      bprev = b_sclk;
      if (cyc == 34) check("b_done_cycle", {b_busy, b_done}, 2'b01);
      if (cyc == 35) check("b_back_to_back", {b_busy, b_done}, 2'b10);
    end
    b_start = 1'b0;
    check("b_busy_cycles", cnt, 33);
    check("b_seq", {16'(rises), bseq}, {16'd16, 16'h8001});
    wait_idle_b();

    // Reset in the middle of a frame aborts it without latch or done.
    wait_idle_a();
    @(negedge clk);
    a_din = 8'hFF; a_lsb = 1'b0; a_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      a_start = 1'b0;
    end
    a_rst = 1'b1;
    @(negedge clk);
    check("a_abort_reset", {a_busy, a_done, a_sclk, a_dout, a_latch, a_oe_n}, 6'b000001);
    a_rst = 1'b0;
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (a_latch || a_done) cnt++;
    end
    check("a_no_latch_after_abort", cnt, 0);

    // Random traffic on both instances, checked cycle by cycle by the model.
    repeat (3000) begin
      @(negedge clk);
      a_start = ($urandom_range(0, 3) == 0);
      a_din   = 8'($urandom);
      a_lsb   = 1'($urandom);
      a_rst   = ($urandom_range(0, 199) == 0);
      b_start = ($urandom_range(0, 3) == 0);
      b_din   = 16'($urandom);
      b_lsb   = 1'($urandom);
      b_rst   = ($urandom_range(0, 199) == 0);
`ifdef SHIFT595_PWM_EN
      if ($urandom_range(0, 63) == 0) a_bright = 8'($urandom);
      if ($urandom_range(0, 63) == 0) b_bright = 8'($urandom);
`endif
    end
    @(negedge clk);
    a_start = 1'b0; a_rst = 1'b0; b_start = 1'b0; b_rst = 1'b0;
    wait_idle_a();
    wait_idle_b();

`ifdef SHIFT595_PWM_EN
    a_bright = 8'd64;
    repeat (4) @(negedge clk);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (!a_oe_n) cnt++;
    end
    check("a_pwm_64", cnt, 64);
    a_bright = 8'd0;
    repeat (4) @(negedge clk);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (!a_oe_n) cnt++;
    end
    check("a_pwm_0", cnt, 0);
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
